hazard_stall_ctrl: RTL and testbench

//  Parametrised successor to the single-cycle load-use detector. Sits beside the ID stage of the 5-stage pipeline.
//  - Detects load-use hazards and holds them for LOAD_STALL_CYC bubbles, for multi-cycle load-to-use latency.
//  - Freezes the whole pipeline while the data cache reports busy.
//  - Gates the ID-resolved branch flush so it only fires when the branch operands are valid.

---
 rtl/hazard_stall_ctrl.sv | 113 +++++++++++
 tb/tb_hazard_stall_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// ID-stage hazard control: load-use bubbles (LOAD_STALL_CYC each), full freeze on cache busy, gated branch flush.
// Outputs are combinational (0-cycle latency); optional perf counters under HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl #(
    parameter int ADDR_W         = 5,
    parameter int LOAD_STALL_CYC = 1,
    parameter int CNT_W          = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ID_EX_MemRead_i,
    input  logic [ADDR_W-1:0] ID_EX_RDaddr_i,
    input  logic [ADDR_W-1:0] IF_ID_RS1addr_i,
    input  logic [ADDR_W-1:0] IF_ID_RS2addr_i,
    input  logic              IF_ID_RS1use_i,
    input  logic              IF_ID_RS2use_i,
    input  logic              mem_stall_i,
    input  logic              branch_taken_i,
    output logic              PCWrite_o,
    output logic              IF_ID_Write_o,
    output logic              ID_EX_Write_o,
    output logic              EX_MEM_Write_o,
    output logic              ID_Flush_lwstall_o,
    output logic              IF_Flush_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  memwait_cnt_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LDSTALL = 2'd1,
        MEMWAIT = 2'd2
    } state_t;

    localparam logic [3:0] INIT_CNT = 4'(LOAD_STALL_CYC - 1);

    state_t     state;
    state_t     ret_state;
    state_t     eff_state;
    logic [3:0] cnt;
    logic       hit;
    logic       lw_stall;
    logic       freeze;

    assign hit = ID_EX_MemRead_i && (ID_EX_RDaddr_i != '0) &&
                 ((IF_ID_RS1use_i && (ID_EX_RDaddr_i == IF_ID_RS1addr_i)) ||
                  (IF_ID_RS2use_i && (ID_EX_RDaddr_i == IF_ID_RS2addr_i)));

    // The cycle mem_stall_i drops, behave as the saved state so no bubble is lost.
    assign eff_state = (state == MEMWAIT) ? ret_state : state;

    assign freeze   = rst_i && mem_stall_i;
    assign lw_stall = rst_i && !mem_stall_i && ((eff_state == LDSTALL) || hit);

    assign PCWrite_o          = !freeze && !lw_stall;
    assign IF_ID_Write_o      = !freeze && !lw_stall;
    assign ID_EX_Write_o      = !freeze;
    assign EX_MEM_Write_o     = !freeze;
    assign ID_Flush_lwstall_o = lw_stall;
    assign IF_Flush_o         = rst_i && branch_taken_i && !mem_stall_i && !lw_stall;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            ret_state <= IDLE;
            cnt       <= 4'd0;
        end else if (mem_stall_i) begin
            state     <= MEMWAIT;
            ret_state <= eff_state;
        end else begin
            case (eff_state)
                IDLE: begin
                    if (hit && (LOAD_STALL_CYC > 1)) begin
                        state <= LDSTALL;
                        cnt   <= INIT_CNT;
                    end else begin
                        state <= IDLE;
                    end
                end
                LDSTALL: begin
                    cnt   <= cnt - 4'd1;
                    state <= (cnt == 4'd1) ? IDLE : LDSTALL;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] memwait_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt   <= '0;
            memwait_cnt <= '0;
        end else begin
            if (lw_stall)
                stall_cnt <= stall_cnt + CNT_ONE;
            if (freeze)
                memwait_cnt <= memwait_cnt + CNT_ONE;
        end
    end

    assign stall_cnt_o   = stall_cnt;
    assign memwait_cnt_o = memwait_cnt;
`else
    assign stall_cnt_o   = '0;
    assign memwait_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: two instances (LOAD_STALL_CYC 1 and 3) share stimulus; queued expectations.
module tb_hazard_stall_ctrl;

    // {PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write, ID_Flush_lwstall, IF_Flush}
    localparam logic [5:0] DEF = 6'b111100;
    localparam logic [5:0] LW  = 6'b001110;
    localparam logic [5:0] FRZ = 6'b000000;
    localparam logic [5:0] BR  = 6'b111101;

    typedef struct {
        string      name;
        logic [5:0] e1;
        logic [5:0] e3;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ld = 1'b0, u1 = 1'b0, u2 = 1'b0, ms = 1'b0, br = 1'b0;
    logic [4:0] rd = '0, rs1 = '0, rs2 = '0;

    logic        pcw1, ifw1, idw1, exw1, fl1, iff1;
    logic        pcw3, ifw3, idw3, exw3, fl3, iff3;
    logic [31:0] sc1, mc1, sc3, mc3;
    logic [5:0]  o1, o3;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          exp_sc1 = 0, exp_sc3 = 0, exp_mw = 0;

    assign o1 = {pcw1, ifw1, idw1, exw1, fl1, iff1};
    assign o3 = {pcw3, ifw3, idw3, exw3, fl3, iff3};

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.ADDR_W(5), .LOAD_STALL_CYC(1), .CNT_W(32)) u_c1 (
        .clk_i(clk), .rst_i(rst),
        .ID_EX_MemRead_i(ld), .ID_EX_RDaddr_i(rd),
        .IF_ID_RS1addr_i(rs1), .IF_ID_RS2addr_i(rs2),
        .IF_ID_RS1use_i(u1), .IF_ID_RS2use_i(u2),
        .mem_stall_i(ms), .branch_taken_i(br),
        .PCWrite_o(pcw1), .IF_ID_Write_o(ifw1), .ID_EX_Write_o(idw1),
        .EX_MEM_Write_o(exw1), .ID_Flush_lwstall_o(fl1), .IF_Flush_o(iff1),
        .stall_cnt_o(sc1), .memwait_cnt_o(mc1)
    );

    hazard_stall_ctrl #(.ADDR_W(5), .LOAD_STALL_CYC(3), .CNT_W(32)) u_c3 (
        .clk_i(clk), .rst_i(rst),
        .ID_EX_MemRead_i(ld), .ID_EX_RDaddr_i(rd),
        .IF_ID_RS1addr_i(rs1), .IF_ID_RS2addr_i(rs2),
        .IF_ID_RS1use_i(u1), .IF_ID_RS2use_i(u2),
        .mem_stall_i(ms), .branch_taken_i(br),
        .PCWrite_o(pcw3), .IF_ID_Write_o(ifw3), .ID_EX_Write_o(idw3),
        .EX_MEM_Write_o(exw3), .ID_Flush_lwstall_o(fl3), .IF_Flush_o(iff3),
        .stall_cnt_o(sc3), .memwait_cnt_o(mc3)
    );

    // One cycle: drive on the falling edge, sample 2ns later, well before the rising edge.
    task automatic step(input string nm, input logic i_ld, input logic [4:0] i_rd,
                        input logic [4:0] i_rs1, input logic [4:0] i_rs2,
                        input logic i_u1, input logic i_u2, input logic i_ms,
                        input logic i_br, input logic [5:0] e1, input logic [5:0] e3);
        exp_t e;
        @(negedge clk);
        ld = i_ld; rd = i_rd; rs1 = i_rs1; rs2 = i_rs2;
        u1 = i_u1; u2 = i_u2; ms = i_ms; br = i_br;
        sb.push_back('{nm, e1, e3});
        if (e1[1]) exp_sc1++;
        if (e3[1]) exp_sc3++;
        if (i_ms)  exp_mw++;
        #2;
        e = sb.pop_front();
        checks++;
        if (o1 !== e.e1) begin
            errors++;
            $display("FAIL %s c1 outputs got %b want %b", e.name, o1, e.e1);
        end
        checks++;
        if (o3 !== e.e3) begin
            errors++;
            $display("FAIL %s c3 outputs got %b want %b", e.name, o3, e.e3);
        end
    endtask

    task automatic check_counters(input string nm);
        logic [31:0] w_sc1, w_sc3, w_mw;
`ifdef HAZARD_PERF_CNT_EN
        w_sc1 = exp_sc1; w_sc3 = exp_sc3; w_mw = exp_mw;
`else
        w_sc1 = 0; w_sc3 = 0; w_mw = 0;
`endif
        checks++;
        if (sc1 !== w_sc1) begin errors++; $display("FAIL %s c1 stall_cnt got %0d want %0d", nm, sc1, w_sc1); end
        checks++;
        if (sc3 !== w_sc3) begin errors++; $display("FAIL %s c3 stall_cnt got %0d want %0d", nm, sc3, w_sc3); end
        checks++;
        if (mc1 !== w_mw) begin errors++; $display("FAIL %s c1 memwait_cnt got %0d want %0d", nm, mc1, w_mw); end
        checks++;
        if (mc3 !== w_mw) begin errors++; $display("FAIL %s c3 memwait_cnt got %0d want %0d", nm, mc3, w_mw); end
    endtask

    task automatic test_reset();
        // Hazard, branch and cache busy all asserted: reset must still force defaults.
        ld = 1; rd = 5; rs1 = 5; u1 = 1; ms = 1; br = 1;
        #12;
        checks++;
        if (o1 !== DEF) begin errors++; $display("FAIL reset c1 outputs got %b want %b", o1, DEF); end
        checks++;
        if (o3 !== DEF) begin errors++; $display("FAIL reset c3 outputs got %b want %b", o3, DEF); end
        check_counters("reset");
        @(negedge clk);
        ld = 0; rd = 0; rs1 = 0; u1 = 0; ms = 0; br = 0;
        rst = 1;
        step("idle_default", 0, 0, 0, 0, 0, 0, 0, 0, DEF, DEF);
    endtask

    task automatic test_load_use();
        step("lu_hit",    1, 5, 5, 0, 1, 0, 0, 0, LW,  LW);
        step("lu_b2",     0, 0, 5, 0, 1, 0, 0, 0, DEF, LW);
        step("lu_b3",     0, 0, 5, 0, 1, 0, 0, 0, DEF, LW);
        step("lu_done",   0, 0, 5, 0, 1, 0, 0, 0, DEF, DEF);
        check_counters("load_use");
    endtask

    task automatic test_no_hazard();
        step("x0_dest",   1, 0, 0, 0, 1, 0, 0, 0, DEF, DEF);
        step("rs2_unused",1, 5, 0, 5, 0, 0, 0, 0, DEF, DEF);
        step("rs1_mismatch",1, 6, 7, 8, 1, 1, 0, 0, DEF, DEF);
        step("rs2_hit",   1, 7, 0, 7, 0, 1, 0, 0, LW,  LW);
        // Hit stays high: c1 restarts a fresh stall each cycle, c3 stays in its run.
        step("rs2_b2",    1, 7, 0, 7, 0, 1, 0, 0, LW,  LW);
        step("rs2_b3",    0, 0, 0, 7, 0, 1, 0, 0, DEF, LW);
        step("rs2_done",  0, 0, 0, 7, 0, 1, 0, 0, DEF, DEF);
    endtask

    task automatic test_mem_stall();
        step("ms_hit",    1, 5, 5, 0, 1, 0, 0, 0, LW,  LW);
        for (int i = 0; i < 4; i++)
            step("ms_freeze", 0, 0, 5, 0, 1, 0, 1, 1, FRZ, FRZ);
        step("ms_b2",     0, 0, 5, 0, 1, 0, 0, 0, DEF, LW);
        step("ms_b3",     0, 0, 5, 0, 1, 0, 0, 0, DEF, LW);
        step("ms_done",   0, 0, 5, 0, 1, 0, 0, 0, DEF, DEF);
        check_counters("mem_stall");
        // Freeze from IDLE with a pending hit: hazard is re-evaluated afterwards.
        step("ms_idle",   1, 9, 9, 0, 1, 0, 1, 0, FRZ, FRZ);
        step("ms_idle_hit",1, 9, 9, 0, 1, 0, 0, 0, LW, LW);
        step("ms_idle_b2",0, 0, 9, 0, 1, 0, 0, 0, DEF, LW);
        step("ms_idle_b3",0, 0, 9, 0, 1, 0, 0, 0, DEF, LW);
        step("ms_idle_done",0, 0, 9, 0, 1, 0, 0, 0, DEF, DEF);
    endtask

    task automatic test_branch();
        step("br_with_hit", 1, 5, 5, 0, 1, 0, 0, 1, LW, LW);
        step("br_next",     0, 0, 5, 0, 1, 0, 0, 1, BR, LW);
        step("br_next2",    0, 0, 5, 0, 1, 0, 0, 1, BR, LW);
        step("br_next3",    0, 0, 5, 0, 1, 0, 0, 1, BR, BR);
        step("br_off",      0, 0, 5, 0, 1, 0, 0, 0, DEF, DEF);
        check_counters("branch");
    endtask

    task automatic test_async_reset();
        step("ar_hit",    1, 5, 5, 0, 1, 0, 0, 0, LW,  LW);
        step("ar_b2",     1, 5, 5, 0, 1, 0, 0, 0, LW,  LW);
        #1;
        rst = 0;
        #1;
        checks++;
        if (o1 !== DEF) begin errors++; $display("FAIL async_reset c1 outputs got %b want %b", o1, DEF); end
        checks++;
        if (o3 !== DEF) begin errors++; $display("FAIL async_reset c3 outputs got %b want %b", o3, DEF); end
        exp_sc1 = 0; exp_sc3 = 0; exp_mw = 0;
        check_counters("async_reset");
        @(negedge clk);
        ld = 0;
        rst = 1;
        step("ar_idle",   0, 0, 5, 0, 1, 0, 0, 0, DEF, DEF);
        check_counters("after_reset");
        step("ar_fresh",  1, 5, 5, 0, 1, 0, 0, 0, LW,  LW);
        step("ar_fresh2", 0, 0, 5, 0, 1, 0, 0, 0, DEF, LW);
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_hazard();
        test_mem_stall();
        test_branch();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
